// File: rtl/fast_cmd_encoder_if.sv
// Fast-command encoder bus: request inputs plus serial line and status.
// master drives requests, slave is the encoder.
interface fast_cmd_encoder_if;
  logic        enable;
  logic        qie_reset_in;
  logic        wte_in;
  logic        ser_out;
  logic        frame_out;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic [11:0] bc_cnt;

  modport master (
    output enable, qie_reset_in, wte_in,
    input  ser_out, frame_out, busy, drop_cnt, bc_cnt
  );

  modport slave (
    input  enable, qie_reset_in, wte_in,
    output ser_out, frame_out, busy, drop_cnt, bc_cnt
  );
endinterface

// File: rtl/fast_cmd_encoder.sv
// Serialises QIE-reset / WTE requests into start+8b+parity frames
// with a forced idle gap, a drop counter and a bunch counter.
module fast_cmd_encoder #(
  parameter logic [7:0]  CMD_QRST = 8'hA5,
  parameter logic [7:0]  CMD_WTE  = 8'h3C,
  parameter int unsigned GAP      = 1
) (
  input logic clk,
  input logic reset_in,
  fast_cmd_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam logic [3:0] GAP_W = 4'(GAP);

  state_t      state;
  logic [3:0]  cnt;
  logic [8:0]  sh;
  logic        ser;
  logic        frame;
  logic        busy;
  logic [7:0]  drop;
  logic [11:0] bc;

  logic q_r, q_p, w_r, w_p;
  logic pend_q, pend_w;

  logic q_cap, w_cap;
  logic launch, go;
  logic take_q, take_w;
  logic drop_q, drop_w;
  logic [1:0] n_drop;
  logic [8:0] drop_sum;
  logic [7:0] drop_nxt;

  assign q_cap = q_r & ~q_p & bus.enable;
  assign w_cap = w_r & ~w_p & bus.enable;

  // a frame may launch from IDLE or straight out of the last gap cycle
  assign launch = (state == ST_IDLE) ||
                  ((state == ST_GAP) && (cnt == GAP_W));
  assign go     = launch & (pend_q | pend_w);
  assign take_q = go & pend_q;
  assign take_w = go & ~pend_q & pend_w;

  assign drop_q   = q_cap & pend_q & ~take_q;
  assign drop_w   = w_cap & pend_w & ~take_w;
  assign n_drop   = {1'b0, drop_q} + {1'b0, drop_w};
  assign drop_sum = {1'b0, drop} + {7'b0, n_drop};
  assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge clk) begin
    if (!reset_in) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sh     <= '0;
      ser    <= 1'b0;
      frame  <= 1'b0;
      busy   <= 1'b0;
      drop   <= '0;
      bc     <= '0;
      pend_q <= 1'b0;
      pend_w <= 1'b0;
      // history follows the level so a held input is not an edge
      q_r    <= bus.qie_reset_in;
      q_p    <= bus.qie_reset_in;
      w_r    <= bus.wte_in;
      w_p    <= bus.wte_in;
    end else begin
      q_r    <= bus.qie_reset_in;
      q_p    <= q_r;
      w_r    <= bus.wte_in;
      w_p    <= w_r;
      pend_q <= (pend_q & ~take_q) | q_cap;
      pend_w <= (pend_w & ~take_w) | w_cap;
      drop   <= drop_nxt;
      bc     <= q_cap ? 12'd0 : bc + 12'd1;

      if (go) begin
        state <= ST_START;
        ser   <= 1'b1;
        frame <= 1'b1;
        busy  <= 1'b1;
        cnt   <= '0;
        sh    <= take_q ? {CMD_QRST, ^CMD_QRST}
                        : {CMD_WTE, ^CMD_WTE};
      end else begin
        unique case (state)
          ST_IDLE: begin
            ser   <= 1'b0;
            frame <= 1'b0;
            busy  <= 1'b0;
          end
          ST_START: begin
            state <= ST_SHIFT;
            ser   <= sh[8];
            sh    <= {sh[7:0], 1'b0};
            cnt   <= '0;
          end
          ST_SHIFT: begin
            if (cnt == 4'd8) begin
              state <= ST_GAP;
              ser   <= 1'b0;
              frame <= 1'b0;
              cnt   <= 4'd1;
            end else begin
              ser <= sh[8];
              sh  <= {sh[7:0], 1'b0};
              cnt <= cnt + 4'd1;
            end
          end
          ST_GAP: begin
            if (cnt == GAP_W) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ser_out   = ser;
  assign bus.frame_out = frame;
  assign bus.busy      = busy;
  assign bus.drop_cnt  = drop;
  assign bus.bc_cnt    = bc;

endmodule

// File: tb/tb_fast_cmd_encoder.sv
// Directed bench for fast_cmd_encoder with hand-computed
// frame bit patterns and counter values.
module tb_fast_cmd_encoder;

  logic clk;
  logic reset_in;
  int   total;
  int   bad;

  fast_cmd_encoder_if bus ();

  fast_cmd_encoder #(
    .CMD_QRST(8'hA5),
    .CMD_WTE (8'h3C),
    .GAP     (1)
  ) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] F_A5 = 10'b1101001010;
  localparam logic [9:0] F_3C = 10'b1001111000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    bus.enable = 1'b1;
    bus.qie_reset_in = 1'b0;
    bus.wte_in = 1'b0;
    tick();
    tick();
    total++;
    if (bus.ser_out !== 1'b0 || bus.frame_out !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_out ser=%b frame=%b busy=%b exp 0 0 0",
               bus.ser_out, bus.frame_out, bus.busy);
    end
    total++;
    if (bus.drop_cnt !== 8'd0 || bus.bc_cnt !== 12'd0) begin
      bad++;
      $display("FAIL reset_cnt drop=%0d bc=%0d exp 0 0", bus.drop_cnt, bus.bc_cnt);
    end
    reset_in = 1'b1;
    tick();
    total++;
    if (bus.bc_cnt !== 12'd1) begin
      bad++;
      $display("FAIL bc_inc got=%0d exp=1", bus.bc_cnt);
    end
    tick();
  endtask

  task automatic test_single_qrst();
    logic [9:0] f;
    f = F_A5;
    bus.qie_reset_in = 1'b1;
    tick();
    bus.qie_reset_in = 1'b0;
    tick();
    total++;
    if (bus.bc_cnt !== 12'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL qrst_capture bc=%0d busy=%b exp 0 0", bus.bc_cnt, bus.busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.ser_out !== f[9-i] || bus.frame_out !== 1'b1 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL qrst_bit%0d ser=%b frame=%b busy=%b exp %b 1 1",
                 i, bus.ser_out, bus.frame_out, bus.busy, f[9-i]);
      end
    end
    tick();
    total++;
    if (bus.ser_out !== 1'b0 || bus.frame_out !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL qrst_gap ser=%b frame=%b busy=%b exp 0 0 1",
               bus.ser_out, bus.frame_out, bus.busy);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.bc_cnt !== 12'd12) begin
      bad++;
      $display("FAIL qrst_end busy=%b bc=%0d exp 0 12", bus.busy, bus.bc_cnt);
    end
  endtask

  task automatic test_both();
    logic [9:0] fa;
    logic [9:0] fw;
    fa = F_A5;
    fw = F_3C;
    bus.qie_reset_in = 1'b1;
    bus.wte_in = 1'b1;
    tick();
    bus.qie_reset_in = 1'b0;
    bus.wte_in = 1'b0;
    tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.ser_out !== fa[9-i] || bus.frame_out !== 1'b1) begin
        bad++;
        $display("FAIL both_a5_bit%0d ser=%b frame=%b exp %b 1",
                 i, bus.ser_out, bus.frame_out, fa[9-i]);
      end
    end
    tick();
    total++;
    if (bus.ser_out !== 1'b0 || bus.frame_out !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL both_gap ser=%b frame=%b busy=%b exp 0 0 1",
               bus.ser_out, bus.frame_out, bus.busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.ser_out !== fw[9-i] || bus.frame_out !== 1'b1) begin
        bad++;
        $display("FAIL both_3c_bit%0d ser=%b frame=%b exp %b 1",
                 i, bus.ser_out, bus.frame_out, fw[9-i]);
      end
    end
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      bad++;
      $display("FAIL both_end busy=%b drop=%0d exp 0 0", bus.busy, bus.drop_cnt);
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_drop();
    logic [9:0] fw;
    logic       hung;
    fw = F_3C;
    bus.qie_reset_in = 1'b1;
    tick();
    bus.qie_reset_in = 1'b0;
    tick();
    for (int p = 0; p < 3; p++) begin
      bus.wte_in = 1'b1;
      tick();
      bus.wte_in = 1'b0;
      tick();
    end
    repeat (5) tick();
    total++;
    if (bus.ser_out !== 1'b0 || bus.busy !== 1'b1 || bus.drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL drop_gap ser=%b busy=%b drop=%0d exp 0 1 2",
               bus.ser_out, bus.busy, bus.drop_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.ser_out !== fw[9-i]) begin
        bad++;
        $display("FAIL drop_wte_bit%0d ser=%b exp %b", i, bus.ser_out, fw[9-i]);
      end
    end
    tick();
    repeat (3) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.drop_cnt !== 8'd2) begin
      bad++;
      $display("FAIL drop_one_frame busy=%b drop=%0d exp 0 2", bus.busy, bus.drop_cnt);
    end
    for (int p = 0; p < 800; p++) begin
      bus.wte_in = 1'b1;
      tick();
      bus.wte_in = 1'b0;
      tick();
    end
    total++;
    if (bus.drop_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL drop_sat got=%0d exp=255", bus.drop_cnt);
    end
    for (int p = 0; p < 100; p++) begin
      bus.wte_in = 1'b1;
      tick();
      bus.wte_in = 1'b0;
      tick();
    end
    total++;
    if (bus.drop_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL drop_hold got=%0d exp=255", bus.drop_cnt);
    end
    hung = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.busy === 1'b0) begin
        hung = 1'b0;
        break;
      end
    end
    total++;
    if (hung !== 1'b0) begin
      bad++;
      $display("FAIL drop_drain busy still high after 40 cycles");
    end
    tick();
    tick();
  endtask

  task automatic test_enable_off();
    int   exp_bc;
    logic act;
    bus.qie_reset_in = 1'b1;
    tick();
    bus.qie_reset_in = 1'b0;
    tick();
    exp_bc = 0;
    repeat (12) tick();
    exp_bc = 12;
    total++;
    if (bus.busy !== 1'b0 || bus.bc_cnt !== 12'(exp_bc)) begin
      bad++;
      $display("FAIL en_pre busy=%b bc=%0d exp 0 %0d", bus.busy, bus.bc_cnt, exp_bc);
    end
    bus.enable = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 4200; i++) begin
      bus.qie_reset_in = ((i % 8) == 0);
      tick();
      exp_bc = (exp_bc + 1) % 4096;
      if (bus.busy !== 1'b0 || bus.frame_out !== 1'b0 || bus.ser_out !== 1'b0)
        act = 1'b1;
      if (exp_bc == 4095) begin
        total++;
        if (bus.bc_cnt !== 12'd4095) begin
          bad++;
          $display("FAIL bc_top got=%0d exp=4095", bus.bc_cnt);
        end
      end
      if (exp_bc == 0) begin
        total++;
        if (bus.bc_cnt !== 12'd0) begin
          bad++;
          $display("FAIL bc_wrap got=%0d exp=0", bus.bc_cnt);
        end
      end
    end
    bus.qie_reset_in = 1'b0;
    tick();
    tick();
    total++;
    if (act !== 1'b0) begin
      bad++;
      $display("FAIL en_off_frames activity=%b exp 0", act);
    end
    total++;
    if (bus.drop_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL en_off_drop got=%0d exp=255", bus.drop_cnt);
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic act;
    bus.wte_in = 1'b1;
    tick();
    tick();
    repeat (4) tick();
    total++;
    if (bus.ser_out !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_bit4 ser=%b busy=%b exp 1 1", bus.ser_out, bus.busy);
    end
    reset_in = 1'b0;
    tick();
    total++;
    if (bus.ser_out !== 1'b0 || bus.busy !== 1'b0 || bus.frame_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_abort ser=%b busy=%b frame=%b exp 0 0 0",
               bus.ser_out, bus.busy, bus.frame_out);
    end
    total++;
    if (bus.drop_cnt !== 8'd0 || bus.bc_cnt !== 12'd0) begin
      bad++;
      $display("FAIL mid_cnt drop=%0d bc=%0d exp 0 0", bus.drop_cnt, bus.bc_cnt);
    end
    reset_in = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.ser_out !== 1'b0) act = 1'b1;
    end
    total++;
    if (act !== 1'b0) begin
      bad++;
      $display("FAIL mid_held_no_edge activity=%b exp 0", act);
    end
    bus.wte_in = 1'b0;
    tick();
    tick();
    bus.wte_in = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (bus.ser_out !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_new_edge ser=%b busy=%b exp 1 1", bus.ser_out, bus.busy);
    end
    bus.wte_in = 1'b0;
    repeat (11) tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_final busy=%b exp 0", bus.busy);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single_qrst();
    test_both();
    test_drop();
    test_enable_off();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
